// File: rtl/lpf_capture_sequencer.sv
// Streams a stored light field, one capture at a time, from frame memory into
// the bit-shift low-pass filter, pacing each capture on the filter's lagged eoc.
//
// state  | meaning
// IDLE   | waiting for start; kernel and drain_err are latched/cleared here
// LOAD   | clear pixel counter for the current capture
// STREAM | one memory read per cycle, IMAGE_DIM^2 reads
// FLUSH  | last read returns and is presented to the filter
// DRAIN  | wait for lpf_eoc_out or the drain timeout
// GAP    | INTER_CAPTURE_GAP idle cycles before the next capture
// DONE   | one-cycle done pulse, back to IDLE
module lpf_capture_sequencer #(
    parameter int IMAGE_DIM         = 64,
    parameter int IMAGE_DIM_BS      = 6,
    parameter int NUM_CAPTURES      = 9,
    parameter int INTER_CAPTURE_GAP = 4,
    parameter int DRAIN_TIMEOUT     = 512,
    parameter int CAP_W             = (NUM_CAPTURES > 1) ? $clog2(NUM_CAPTURES) : 1,
    parameter int ADDR_W            = CAP_W + 2*IMAGE_DIM_BS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        kernel_sw,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic [1:0]        lpf_kernel_size,
    output logic              lpf_pixel_valid,
    output logic [23:0]       lpf_pixel,
    output logic              lpf_soc,
    output logic              lpf_eoc,
    output logic              lpf_solf,
    output logic              lpf_eolf,
    input  logic              lpf_eoc_out,
    output logic              busy,
    output logic              done,
    output logic              drain_err,
    output logic [CAP_W-1:0]  capture_idx
);

    localparam int PIX_W = 2*IMAGE_DIM_BS;
    localparam int DR_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int GAP_W = $clog2(INTER_CAPTURE_GAP + 1);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_DIM*IMAGE_DIM - 1);
    localparam logic [DR_W-1:0]  DR_LOAD  = DR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(INTER_CAPTURE_GAP - 1);
    localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(NUM_CAPTURES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_DRAIN, S_GAP, S_DONE
    } state_t;

    state_t            state, state_next;
    logic [PIX_W-1:0]  pix_cnt;
    logic [DR_W-1:0]   drain_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              first_pix;
    logic              last_pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   state_next = S_STREAM;
            S_STREAM: if (pix_cnt == PIX_LAST) state_next = S_FLUSH;
            S_FLUSH:  state_next = S_DRAIN;
            S_DRAIN:  if (lpf_eoc_out || drain_cnt == '0) state_next = S_GAP;
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_next = (capture_idx == CAP_LAST) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign mem_rd_en = (state == S_STREAM);
    assign mem_addr  = ADDR_W'({capture_idx, pix_cnt});
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign first_pix = mem_rd_en && (pix_cnt == '0);
    assign last_pix  = mem_rd_en && (pix_cnt == PIX_LAST);

    // The memory's own output register is the pixel stage; masking keeps the
    // pixel bus at zero whenever no valid pixel is being presented.
    assign lpf_pixel = lpf_pixel_valid ? mem_rdata : 24'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt         <= '0;
            drain_cnt       <= '0;
            gap_cnt         <= '0;
            capture_idx     <= '0;
            lpf_kernel_size <= 2'b00;
            drain_err       <= 1'b0;
            lpf_pixel_valid <= 1'b0;
            lpf_soc         <= 1'b0;
            lpf_eoc         <= 1'b0;
            lpf_solf        <= 1'b0;
            lpf_eolf        <= 1'b0;
        end else begin
            lpf_pixel_valid <= mem_rd_en;
            lpf_soc         <= first_pix;
            lpf_eoc         <= last_pix;
            lpf_solf        <= first_pix && (capture_idx == '0);
            lpf_eolf        <= last_pix && (capture_idx == CAP_LAST);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        lpf_kernel_size <= kernel_sw;
                        drain_err       <= 1'b0;
                        capture_idx     <= '0;
                    end
                end
                S_LOAD:   pix_cnt <= '0;
                S_STREAM: pix_cnt <= pix_cnt + PIX_W'(1);
                S_FLUSH:  drain_cnt <= DR_LOAD;
                S_DRAIN: begin
                    gap_cnt <= GAP_LOAD;
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - DR_W'(1);
                    // a late eoc landing on the timeout cycle still counts as success
                    if (!lpf_eoc_out && drain_cnt == '0) drain_err <= 1'b1;
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end else if (capture_idx != CAP_LAST) begin
                        capture_idx <= capture_idx + CAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
